// File: rtl/wra_pkg.sv
// Shared definitions for the WRA instruction path: config field layout,
// instruction flag positions and the decoder state encoding.
package wra_pkg;

    localparam int INSTR_W_DEF   = 64;
    localparam int CFG_W_DEF     = 60;
    localparam int DONE_BIT_DEF  = 60;
    localparam int RDRES_BIT_DEF = 61;

    // Bit offsets of the WRA config sub-fields inside instr[CFG_W-1:0].
    localparam int STRIDE_LSB  = 0;
    localparam int KSIZE_LSB   = 4;
    localparam int NSLIDEH_LSB = 8;
    localparam int NSLIDEV_LSB = 18;
    localparam int SRCADDR_LSB = 28;
    localparam int DSTADDR_LSB = 40;
    localparam int DMASIZE_LSB = 52;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/wra_cfg_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded WRA configs.
// Pointers carry a wrap bit so full and empty are distinguishable.
module wra_cfg_fifo #(
    parameter int WIDTH = 61,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/wra_instr_decoder.sv
// Buffered decoder between InstrMem and WRA: queues decoded configs, presents
// them to WRA, and reports model completion once the queue has drained.
module wra_instr_decoder
    import wra_pkg::*;
#(
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 CFG_W     = CFG_W_DEF,
    parameter int                 DONE_BIT  = DONE_BIT_DEF,
    parameter int                 RDRES_BIT = RDRES_BIT_DEF,
    parameter int                 DEPTH     = 4,
    parameter logic [CFG_W-1:0]   CFG_RST   = {CFG_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INSTR_W-1:0]         instr_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    output logic [CFG_W-1:0]           cfg_o,
    output logic                       cfg_valid_o,
    input  logic                       cfg_ready_i,
    output logic                       read_result_o,
    output logic                       model_done_o,
    input  logic                       start_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     level_o
);

    dec_state_e     state_q, state_d;
    logic           model_done_d;
    logic           read_result_d;
    logic           push, pop, fifo_push, is_done;
    logic           full, empty;
    logic [CFG_W:0] head;
    logic           unused_instr;

    assign is_done      = instr_i[DONE_BIT];
    assign unused_instr = ^instr_i;

    // Readiness depends only on state and fill level; a same-cycle pop never
    // opens a slot for a push.
    assign instr_ready_o = (state_q == ST_RUN) && !full;
    assign push          = instr_valid_i && instr_ready_o;
    assign fifo_push     = push && !is_done;
    assign cfg_valid_o   = !empty;
    assign pop           = cfg_valid_o && cfg_ready_i;
    assign cfg_o         = empty ? CFG_RST : head[CFG_W-1:0];

    wra_cfg_fifo #(
        .WIDTH (CFG_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_i),
        .push  (fifo_push),
        .wdata ({instr_i[RDRES_BIT], instr_i[CFG_W-1:0]}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // NOTE: every signal written here gets a default first so no latch forms.
    always_comb begin
        state_d       = state_q;
        model_done_d  = 1'b0;
        read_result_d = pop && head[CFG_W];
        unique case (state_q)
            ST_RUN:   if (push && is_done) state_d = ST_DRAIN;
            ST_DRAIN: if (empty) begin
                          state_d      = ST_DONE;
                          model_done_d = 1'b1;
                      end
            ST_DONE:  if (start_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (flush_i) begin
            state_d       = ST_RUN;
            model_done_d  = 1'b0;
            read_result_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            model_done_o  <= 1'b0;
            read_result_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            model_done_o  <= model_done_d;
            read_result_o <= read_result_d;
        end
    end

endmodule

// File: tb/tb_wra_instr_decoder.sv
// Directed self-checking bench for wra_instr_decoder; inputs change 1 time
// unit after the rising edge and outputs are compared at that same point.
module tb_wra_instr_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [59:0] cfg;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        read_result;
    logic        model_done;
    logic        start;
    logic        flush;
    logic [2:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [59:0] CFG_ONES = 60'hFFF_FFFF_FFFF_FFFF;

    wra_instr_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_i       (instr),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .cfg_o         (cfg),
        .cfg_valid_o   (cfg_valid),
        .cfg_ready_i   (cfg_ready),
        .read_result_o (read_result),
        .model_done_o  (model_done),
        .start_i       (start),
        .flush_i       (flush),
        .level_o       (level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(input logic done, input logic rd, input logic [59:0] c);
        return {2'b00, rd, done, c};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; cfg_ready = 1'b0;
        start = 1'b0; flush = 1'b0;
        #12;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_valid: got %b expected 0", cfg_valid); end
        n_checks++; if (cfg !== CFG_ONES) begin n_fail++; $display("FAIL reset_cfg: got %h expected %h", cfg, CFG_ONES); end
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_instr_ready: got %b expected 1", instr_ready); end
        n_checks++; if ({read_result, model_done} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {read_result, model_done}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        logic [59:0] a = 60'h123_4567_89AB_CDEF;
        logic [59:0] b = 60'h0F0_F0F0_F0F0_F0F0;
        logic [59:0] c = 60'h555_AAAA_5555_AAAA;
        cfg_ready = 1'b1;
        instr = mk(1'b0, 1'b0, a); instr_valid = 1'b1;
        step();
        n_checks++; if (cfg !== a || cfg_valid !== 1'b1) begin n_fail++; $display("FAIL stream_a: got %h/%b expected %h/1", cfg, cfg_valid, a); end
        instr = mk(1'b0, 1'b1, b);
        step();
        n_checks++; if (cfg !== b) begin n_fail++; $display("FAIL stream_b: got %h expected %h", cfg, b); end
        n_checks++; if (read_result !== 1'b0) begin n_fail++; $display("FAIL stream_rr_after_a: got %b expected 0", read_result); end
        instr = mk(1'b0, 1'b0, c);
        step();
        n_checks++; if (cfg !== c) begin n_fail++; $display("FAIL stream_c: got %h expected %h", cfg, c); end
        n_checks++; if (read_result !== 1'b1) begin n_fail++; $display("FAIL stream_rr_after_b: got %b expected 1", read_result); end
        instr_valid = 1'b0;
        step();
        n_checks++; if (read_result !== 1'b0) begin n_fail++; $display("FAIL stream_rr_after_c: got %b expected 0", read_result); end
        n_checks++; if (cfg_valid !== 1'b0 || cfg !== CFG_ONES || level !== 3'd0) begin n_fail++; $display("FAIL stream_empty: got %b/%h/%0d expected 0/%h/0", cfg_valid, cfg, level, CFG_ONES); end
        cfg_ready = 1'b0;
        step();
    endtask

    task automatic test_full();
        logic [59:0] d [5];
        for (int i = 0; i < 5; i++) d[i] = 60'hA00_0000_0000_0000 + 60'(i * 17 + 3);
        cfg_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr = mk(1'b0, (i == 0), d[i]); instr_valid = 1'b1;
            step();
        end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", level); end
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", instr_ready); end
        instr = mk(1'b0, 1'b0, d[4]);
        step();
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_hold_level: got %0d expected 4", level); end
        cfg_ready = 1'b1;
        step();
        n_checks++; if (level !== 3'd3 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_frees: got level %0d ready %b expected 3/1", level, instr_ready); end
        n_checks++; if (read_result !== 1'b1) begin n_fail++; $display("FAIL full_rr_d0: got %b expected 1", read_result); end
        cfg_ready = 1'b0;
        step();
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_fifth_accepted: got %0d expected 4", level); end
        instr_valid = 1'b0; cfg_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (cfg !== d[i]) begin n_fail++; $display("FAIL full_order_%0d: got %h expected %h", i, cfg, d[i]); end
            step();
        end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", level); end
        cfg_ready = 1'b0;
        step();
    endtask

    task automatic test_done_drain();
        int pulses = 0;
        cfg_ready = 1'b0;
        instr = mk(1'b0, 1'b0, 60'h111); instr_valid = 1'b1;
        step();
        instr = mk(1'b0, 1'b0, 60'h222);
        step();
        instr = mk(1'b1, 1'b0, 60'h333);
        step();
        n_checks++; if (instr_ready !== 1'b0 || level !== 3'd2) begin n_fail++; $display("FAIL drain_entry: got ready %b level %0d expected 0/2", instr_ready, level); end
        instr_valid = 1'b0;
        step();
        n_checks++; if (model_done !== 1'b0) begin n_fail++; $display("FAIL drain_early_done: got %b expected 0", model_done); end
        cfg_ready = 1'b1;
        step();
        n_checks++; if (model_done !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL drain_pop1: got done %b level %0d expected 0/1", model_done, level); end
        step();
        n_checks++; if (model_done !== 1'b0 || level !== 3'd0 || instr_ready !== 1'b0) begin n_fail++; $display("FAIL drain_pop2: got done %b level %0d ready %b expected 0/0/0", model_done, level, instr_ready); end
        step();
        n_checks++; if (model_done !== 1'b1) begin n_fail++; $display("FAIL drain_pulse: got %b expected 1", model_done); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (model_done === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL drain_single_pulse: got %0d extra pulses expected 0", pulses); end
        n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL drain_done_ready: got %b expected 0", instr_ready); end
        cfg_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL drain_start: got %b expected 1", instr_ready); end
    endtask

    task automatic test_done_empty();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL empty_start_ignored: got %b expected 1", instr_ready); end
        instr = mk(1'b1, 1'b1, 60'hABC); instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        n_checks++; if (model_done !== 1'b0 || instr_ready !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL empty_done_t1: got done %b ready %b level %0d expected 0/0/0", model_done, instr_ready, level); end
        step();
        n_checks++; if (model_done !== 1'b1) begin n_fail++; $display("FAIL empty_done_t2: got %b expected 1", model_done); end
        step();
        n_checks++; if (model_done !== 1'b0) begin n_fail++; $display("FAIL empty_done_t3: got %b expected 0", model_done); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL empty_restart: got %b expected 1", instr_ready); end
    endtask

    task automatic test_flush();
        cfg_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr = mk(1'b0, 1'b1, 60'(32'hF000 + i)); instr_valid = 1'b1;
            step();
        end
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_level: got %0d expected 3", level); end
        instr = mk(1'b0, 1'b1, 60'hF003); flush = 1'b1; cfg_ready = 1'b1;
        step();
        flush = 1'b0; instr_valid = 1'b0; cfg_ready = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", level); end
        n_checks++; if (cfg !== CFG_ONES || cfg_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cfg: got %h/%b expected %h/0", cfg, cfg_valid, CFG_ONES); end
        n_checks++; if (read_result !== 1'b0) begin n_fail++; $display("FAIL flush_rr: got %b expected 0", read_result); end
        step();
        n_checks++; if (level !== 3'd0 || instr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: got level %0d ready %b expected 0/1", level, instr_ready); end
    endtask

    task automatic test_async_reset();
        int pulses = 0;
        cfg_ready = 1'b0;
        instr = mk(1'b0, 1'b1, 60'h777); instr_valid = 1'b1;
        step();
        instr = mk(1'b1, 1'b0, 60'h0);
        step();
        instr_valid = 1'b0;
        n_checks++; if (instr_ready !== 1'b0 || level !== 3'd1) begin n_fail++; $display("FAIL arst_pre: got ready %b level %0d expected 0/1", instr_ready, level); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (level !== 3'd0 || cfg_valid !== 1'b0 || cfg !== CFG_ONES) begin n_fail++; $display("FAIL arst_queue: got %0d/%b/%h expected 0/0/%h", level, cfg_valid, cfg, CFG_ONES); end
        n_checks++; if (instr_ready !== 1'b1 || model_done !== 1'b0 || read_result !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl: got ready %b done %b rr %b expected 1/0/0", instr_ready, model_done, read_result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (model_done !== 1'b0) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL arst_no_done: got %0d pulses expected 0", pulses); end
        n_checks++; if (instr_ready !== 1'b1 || level !== 3'd0) begin n_fail++; $display("FAIL arst_run: got ready %b level %0d expected 1/0", instr_ready, level); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_done_drain();
        test_done_empty();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
